// File: rtl/shl_seq.sv
// Multi-cycle logical left shifter: up to STEP bit positions per clock, start/busy/done handshake.
// Define SHL_OVF_EN to add the ovf output (OR of all bits shifted out of the MSB end).
//
// state | meaning
// IDLE  | waiting for start; d/ovf hold the last result
// SHIFT | shifting acc by min(rem, STEP) each cycle until rem reaches zero
module shl_seq #(
  parameter int DATAWIDTH = 64,
  parameter int STEP      = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  output logic [DATAWIDTH-1:0] d,
  output logic                 busy,
`ifdef SHL_OVF_EN
  output logic                 ovf,
`endif
  output logic                 done
);

  localparam int RW = $clog2(DATAWIDTH) + 1;
  localparam logic [DATAWIDTH-1:0] DW_FULL = DATAWIDTH'(DATAWIDTH);
  localparam logic [RW-1:0]        DW_REM  = RW'(DATAWIDTH);
  localparam logic [RW-1:0]        STEP_R  = RW'(STEP);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state, state_nx;
  logic [DATAWIDTH-1:0]     acc, acc_nx, d_nx;
  logic [RW-1:0]            rem, rem_nx;
  logic                     done_nx;
  logic [RW-1:0]            c, k;
  logic [2*DATAWIDTH-1:0]   wide;
  logic [DATAWIDTH-1:0]     shifted;
`ifdef SHL_OVF_EN
  logic                     ovf_acc, ovf_acc_nx, ovf_nx, spill;
`endif

  // Clamp is decided on the full operand width so huge amounts still give zero.
  assign c = (sh_amt >= DW_FULL) ? DW_REM : sh_amt[RW-1:0];
  assign k = (rem > STEP_R) ? STEP_R : rem;

  // Upper half of the double-width shift holds the bits pushed past the MSB.
  assign wide    = {{DATAWIDTH{1'b0}}, acc} << k;
  assign shifted = wide[DATAWIDTH-1:0];
  assign busy    = (state == SHIFT);
`ifdef SHL_OVF_EN
  assign spill   = |wide[2*DATAWIDTH-1:DATAWIDTH];
`endif

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    rem_nx   = rem;
    d_nx     = d;
    done_nx  = 1'b0;
`ifdef SHL_OVF_EN
    ovf_nx     = ovf;
    ovf_acc_nx = ovf_acc;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (c == '0) begin
            d_nx    = a;
            done_nx = 1'b1;
`ifdef SHL_OVF_EN
            ovf_nx  = 1'b0;
`endif
          end else begin
            acc_nx   = a;
            rem_nx   = c;
            state_nx = SHIFT;
`ifdef SHL_OVF_EN
            ovf_acc_nx = 1'b0;
`endif
          end
        end
      end
      SHIFT: begin
        acc_nx = shifted;
        rem_nx = rem - k;
`ifdef SHL_OVF_EN
        ovf_acc_nx = ovf_acc | spill;
`endif
        if (rem == k) begin
          d_nx     = shifted;
          done_nx  = 1'b1;
          state_nx = IDLE;
`ifdef SHL_OVF_EN
          ovf_nx   = ovf_acc | spill;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      d     <= '0;
      done  <= 1'b0;
`ifdef SHL_OVF_EN
      ovf     <= 1'b0;
      ovf_acc <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      rem   <= rem_nx;
      d     <= d_nx;
      done  <= done_nx;
`ifdef SHL_OVF_EN
      ovf     <= ovf_nx;
      ovf_acc <= ovf_acc_nx;
`endif
    end
  end

endmodule

// File: tb/tb_shl_seq.sv
// Directed self-checking bench for shl_seq (DATAWIDTH=64, STEP=8).
// Checks ovf as well when SHL_OVF_EN is defined.
module tb_shl_seq;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [63:0] a;
  logic [63:0] sh_amt;
  logic [63:0] d;
  logic        busy;
  logic        done;
`ifdef SHL_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;
  int lat;

  shl_seq #(.DATAWIDTH(64), .STEP(8)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .start  (start),
    .a      (a),
    .sh_amt (sh_amt),
    .d      (d),
    .busy   (busy),
`ifdef SHL_OVF_EN
    .ovf    (ovf),
`endif
    .done   (done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one start, then wait (bounded) for done; lat = cycles from start to done.
  task automatic run_op(input logic [63:0] av, input logic [63:0] sv, output int n);
    a      = av;
    sh_amt = sv;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  initial begin
    Rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    sh_amt = '0;
    tick();
    tick();
    chk("rst_d", d, 64'h0);
    chk("rst_busy", {63'b0, busy}, 64'h0);
    chk("rst_done", {63'b0, done}, 64'h0);
    Rst = 1'b0;
    tick();

    // zero shift: done next cycle, never busy
    run_op(64'h1, 64'h0, lat);
    chk("zero_lat", 64'(lat), 64'd1);
    chk("zero_d", d, 64'h1);
    chk("zero_busy", {63'b0, busy}, 64'h0);
`ifdef SHL_OVF_EN
    chk("zero_ovf", {63'b0, ovf}, 64'h0);
`endif
    tick();
    chk("zero_done_drop", {63'b0, done}, 64'h0);
    chk("zero_d_hold", d, 64'h1);

    // shift by 20: busy T+1..T+3, done T+4
    a = 64'hFF; sh_amt = 64'd20; start = 1'b1;
    tick();
    start = 1'b0;
    chk("s20_busy1", {63'b0, busy}, 64'h1);
    tick();
    chk("s20_busy2", {63'b0, busy}, 64'h1);
    tick();
    chk("s20_busy3", {63'b0, busy}, 64'h1);
    chk("s20_nodone3", {63'b0, done}, 64'h0);
    tick();
    chk("s20_done", {63'b0, done}, 64'h1);
    chk("s20_busy_off", {63'b0, busy}, 64'h0);
    chk("s20_d", d, 64'h0FF00000);
    tick();

    // clamped shifts
    run_op(64'hDEAD, 64'd64, lat);
    chk("s64_lat", 64'(lat), 64'd9);
    chk("s64_d", d, 64'h0);
`ifdef SHL_OVF_EN
    chk("s64_ovf", {63'b0, ovf}, 64'h1);
`endif
    tick();
    run_op(64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    chk("sall_lat", 64'(lat), 64'd9);
    chk("sall_d", d, 64'h0);
`ifdef SHL_OVF_EN
    chk("sall_ovf", {63'b0, ovf}, 64'h1);
`endif
    tick();

    // odd amount 13 -> 2 shift cycles (8 + 5)
    run_op(64'h1234, 64'd13, lat);
    chk("s13_lat", 64'(lat), 64'd3);
    chk("s13_d", d, 64'h0246_8000);
    tick();

    // start ignored while busy, back-to-back start in done cycle
    a = 64'h3; sh_amt = 64'd9; start = 1'b1;
    tick();
    a = 64'h5; sh_amt = 64'd1;
    tick();
    chk("ign_busy", {63'b0, busy}, 64'h1);
    start = 1'b0; a = 64'h0; sh_amt = 64'h0;
    tick();
    chk("ign_done", {63'b0, done}, 64'h1);
    chk("ign_d", d, 64'h600);
    a = 64'h1; sh_amt = 64'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy", {63'b0, busy}, 64'h1);
    chk("b2b_nodone", {63'b0, done}, 64'h0);
    tick();
    chk("b2b_done", {63'b0, done}, 64'h1);
    chk("b2b_d", d, 64'h2);

    // consecutive zero-shift starts keep done high
    a = 64'hA5; sh_amt = 64'd0; start = 1'b1;
    tick();
    chk("z2_done1", {63'b0, done}, 64'h1);
    a = 64'h5A;
    tick();
    start = 1'b0;
    chk("z2_done2", {63'b0, done}, 64'h1);
    chk("z2_d", d, 64'h5A);
    tick();

    // reset mid-operation aborts with no done pulse
    a = 64'hFF; sh_amt = 64'd40; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'h0);
    chk("abort_done", {63'b0, done}, 64'h0);
    chk("abort_d", d, 64'h0);
`ifdef SHL_OVF_EN
    chk("abort_ovf", {63'b0, ovf}, 64'h0);
`endif
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (done === 1'b1) seen = 1'b1;
      end
      chk("abort_no_done", {63'b0, seen}, 64'h0);
    end

`ifdef SHL_OVF_EN
    run_op(64'h8000_0000_0000_0000, 64'd1, lat);
    chk("ovf1_lat", 64'(lat), 64'd2);
    chk("ovf1_d", d, 64'h0);
    chk("ovf1_ovf", {63'b0, ovf}, 64'h1);
    tick();
    run_op(64'h1, 64'd63, lat);
    chk("ovf63_lat", 64'(lat), 64'd9);
    chk("ovf63_d", d, 64'h8000_0000_0000_0000);
    chk("ovf63_ovf", {63'b0, ovf}, 64'h0);
    tick();
`else
    run_op(64'h8000_0000_0000_0000, 64'd1, lat);
    chk("msb1_lat", 64'(lat), 64'd2);
    chk("msb1_d", d, 64'h0);
    tick();
    run_op(64'h1, 64'd63, lat);
    chk("s63_lat", 64'(lat), 64'd9);
    chk("s63_d", d, 64'h8000_0000_0000_0000);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
